music_sequencer: RTL

//   Beat-timed address generator and note latch that drives the music ROM. It steps

---
 rtl/music_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/music_sequencer.sv
// Beat-timed music ROM address generator and two-note latch with play/pause/restart.
// Define MUSIC_LOOP_EN to loop back to address 0 at end of tune instead of stopping.
module music_sequencer #(
  parameter int         CLK_HZ   = 100_000_000,
  parameter int         BEAT_HZ  = 8,
  parameter int         ADDR_W   = 10,
  parameter int         TUNE_LEN = 512,
  parameter logic [6:0] END_CODE = 7'h7F
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              play,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [6:0]        rom_note1,
  input  logic [6:0]        rom_note2,
  output logic [6:0]        note1,
  output logic [6:0]        note2,
  output logic              beat_strobe,
  output logic              playing,
  output logic              tune_done
);
  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int PRE_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BEAT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TUNE_LEN - 1);
`ifdef MUSIC_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    HOLD  = 3'd3,
    PAUSE = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [PRE_W-1:0]   presc, presc_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [6:0]         note1_next, note2_next;
  logic               strobe_next, done_next, playing_next;
  // Set after a non-looping end of tune: play must drop before playback restarts.
  logic               rearm_wait, rearm_wait_next;
  logic               finish;

  // Next-state, prescaler, address and note selection.
  always_comb begin
    state_next      = state;
    presc_next      = presc;
    addr_next       = rom_addr;
    note1_next      = note1;
    note2_next      = note2;
    strobe_next     = 1'b0;
    done_next       = 1'b0;
    rearm_wait_next = rearm_wait & play;
    finish          = 1'b0;
    if (restart) begin
      addr_next       = '0;
      presc_next      = '0;
      note1_next      = 7'd0;
      note2_next      = 7'd0;
      rearm_wait_next = 1'b0;
      state_next      = play ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          note1_next = 7'd0;
          note2_next = 7'd0;
          if (play && !rearm_wait) begin
            state_next = FETCH;
            presc_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
        PAUSE: begin
          if (play) state_next = FETCH;
          else      state_next = PAUSE;
        end
        FETCH, READ, HOLD: begin
          if (!play) begin
            state_next = PAUSE;
            note1_next = 7'd0;
            note2_next = 7'd0;
          end else if (state == READ && rom_note1 == END_CODE) begin
            finish     = 1'b1;
            note1_next = 7'd0;
            note2_next = 7'd0;
          end else begin
            state_next = (state == FETCH) ? READ : HOLD;
            if (state == READ) begin
              note1_next = rom_note1;
              note2_next = rom_note2;
            end else begin
              note1_next = note1;
              note2_next = note2;
            end
            // Terminal count closes the beat; the fetch cycles belong to the beat.
            if (presc == PRE_LAST) begin
              strobe_next = 1'b1;
              presc_next  = '0;
              if (rom_addr == ADDR_LAST) begin
                finish = 1'b1;
              end else begin
                addr_next  = rom_addr + ADDR_W'(1);
                state_next = FETCH;
              end
            end else begin
              presc_next = presc + PRE_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (finish) begin
        done_next  = 1'b1;
        addr_next  = '0;
        presc_next = '0;
        if (LOOP) begin
          state_next = FETCH;
        end else begin
          state_next      = IDLE;
          rearm_wait_next = 1'b1;
          note1_next      = 7'd0;
          note2_next      = 7'd0;
        end
      end else begin
        done_next = 1'b0;
      end
    end
    playing_next = (state_next == FETCH) || (state_next == READ) || (state_next == HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      rom_addr    <= '0;
      note1       <= 7'd0;
      note2       <= 7'd0;
      beat_strobe <= 1'b0;
      tune_done   <= 1'b0;
      playing     <= 1'b0;
      rearm_wait  <= 1'b0;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      rom_addr    <= addr_next;
      note1       <= note1_next;
      note2       <= note2_next;
      beat_strobe <= strobe_next;
      tune_done   <= done_next;
      playing     <= playing_next;
      rearm_wait  <= rearm_wait_next;
    end
  end
endmodule
